// File: rtl/idu0_wide.sv
// idu0_wide: eBPF decode stage 0. Extracts slot fields, fuses the two-slot lddw
// into one 64-bit-immediate entry, and buffers results in an OUT_DEPTH FIFO.
module idu0_wide #(
  parameter int unsigned INSTR_LEN = 64,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned OUT_DEPTH = 2,
  parameter logic [7:0]  LDDW_OPC  = 8'h18
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [INSTR_LEN-1:0] in_instr,
  input  logic [XLEN-1:0]      in_tag,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 pipe_flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_LEN-1:0] out_instr,
  output logic [XLEN-1:0]      out_tag,
  output logic [3:0]           out_rd_addr,
  output logic [3:0]           out_rs1_addr,
  output logic [3:0]           out_rs2_addr,
  output logic [15:0]          out_off,
  output logic [XLEN-1:0]      out_imm,
  output logic                 out_wide,
  output logic                 out_illegal,
  output logic                 hi_pending
);

  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUT_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_HI
  } state_t;

  state_t                 state;
  logic                   hi_pending_q;
  logic [INSTR_LEN-1:0]   hold_instr;
  logic [XLEN-1:0]        hold_tag;

  logic [INSTR_LEN-1:0]   mem_instr [OUT_DEPTH];
  logic [XLEN-1:0]        mem_tag   [OUT_DEPTH];
  logic [XLEN-1:0]        mem_imm   [OUT_DEPTH];
  logic                   mem_wide  [OUT_DEPTH];
  logic                   mem_ill   [OUT_DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic                   in_ready_q;

  logic                   accept;
  logic                   is_lddw;
  logic                   push;
  logic                   pop;
  logic [INSTR_LEN-1:0]   push_instr;
  logic [XLEN-1:0]        push_tag;
  logic [XLEN-1:0]        push_imm;
  logic                   push_wide;
  logic                   push_ill;

  assign in_ready   = in_ready_q;
  assign hi_pending = hi_pending_q;
  assign out_valid  = (count != '0);
  assign accept     = in_valid & in_ready_q;
  assign is_lddw    = (in_instr[7:0] == LDDW_OPC);
  assign pop        = out_valid & out_ready;

  always_comb begin
    push       = 1'b0;
    push_instr = in_instr;
    push_tag   = in_tag;
    push_imm   = XLEN'($signed(in_instr[63:32]));
    push_wide  = 1'b0;
    push_ill   = 1'b0;
    if (accept && !pipe_flush) begin
      if (state == ST_WAIT_HI) begin
        // Any slot in WAIT_HI completes the lddw, even another lddw opcode.
        push       = 1'b1;
        push_instr = hold_instr;
        push_tag   = hold_tag;
        push_imm   = XLEN'({in_instr[63:32], hold_instr[63:32]});
        push_wide  = 1'b1;
        push_ill   = (in_instr[31:0] != '0);
      end else begin
        push = !is_lddw;
      end
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      hi_pending_q <= 1'b0;
      hold_instr   <= '0;
      hold_tag     <= '0;
    end else if (pipe_flush) begin
      state        <= ST_IDLE;
      hi_pending_q <= 1'b0;
      hold_instr   <= '0;
      hold_tag     <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (is_lddw) begin
            state        <= ST_WAIT_HI;
            hi_pending_q <= 1'b1;
            hold_instr   <= in_instr;
            hold_tag     <= in_tag;
          end
        end
        ST_WAIT_HI: begin
          state        <= ST_IDLE;
          hi_pending_q <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          hi_pending_q <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is the registered image of count_next, so it never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_tag[i]   <= '0;
        mem_imm[i]   <= '0;
        mem_wide[i]  <= 1'b0;
        mem_ill[i]   <= 1'b0;
      end
    end else if (pipe_flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= push_instr;
        mem_tag[wr_ptr]   <= push_tag;
        mem_imm[wr_ptr]   <= push_imm;
        mem_wide[wr_ptr]  <= push_wide;
        mem_ill[wr_ptr]   <= push_ill;
        wr_ptr            <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      count      <= count_next;
      in_ready_q <= (count_next < DEPTH_C);
    end
  end

  assign out_instr    = mem_instr[rd_ptr];
  assign out_tag      = mem_tag[rd_ptr];
  assign out_imm      = mem_imm[rd_ptr];
  assign out_wide     = mem_wide[rd_ptr];
  assign out_illegal  = mem_ill[rd_ptr];
  assign out_rd_addr  = out_instr[11:8];
  assign out_rs1_addr = out_instr[11:8];
  assign out_rs2_addr = out_instr[15:12];
  assign out_off      = out_instr[31:16];

endmodule
